wb_led_ctrl: RTL and testbench

Parametrised Wishbone-slave LED/status-output controller for the Caravel user area. It is the generalised successor of the fixed 7-bit free-running LED counter and replaces the stubbed Wishbone path (`wbs_ack_o` tied 0) with a real register interface. It supports NUM_CH channels, a programmable prescaler, and three output modes: binary count, per-channel PWM and static. Outputs drive `io_out` pads together with the matching `io_oeb` bits.

---
 rtl/wb_led_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_wb_led_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_led_ctrl.sv
// Wishbone LED/status controller: count, PWM and static output modes.
// Define LED_IRQ_EN to enable the wrap interrupt and the CTRL.ie bit.
module wb_led_ctrl #(
   parameter int          NUM_CH    = 7,
   parameter int          CNT_W     = 20,
   parameter int          PWM_W     = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_dat_i,
   input  logic [31:0]       wbs_adr_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [NUM_CH-1:0] led_o,
   output logic [NUM_CH-1:0] led_oeb_o,
   output logic              irq_o
);

   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic              en_q, en_d;
   logic [1:0]        mode_q, mode_d;
   logic [CNT_W-1:0]  prescale_q, prescale_d;
   logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic [NUM_CH-1:0] out_q, out_d;
   logic [NUM_CH-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0] led_q, led_d;
   logic [PWM_W-1:0]  duty_q [NUM_CH];
   logic [PWM_W-1:0]  duty_d [NUM_CH];

   logic              ie_q;
   logic              hit, req, wr, cfg_wr, tick;
   logic [5:0]        off;
   logic [31:0]       wmask, rdata;
   logic [NUM_CH-1:0] pwm_led;
   logic              unused_bits;

   assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign req    = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
   assign wr     = req & wbs_we_i;
   assign off    = wbs_adr_i[7:2];
   assign cfg_wr = wr & ((off == 6'd0) | (off == 6'd1));
   // A config write restarts the prescaler and suppresses this cycle's tick.
   assign tick   = en_q & ~cfg_wr & (pre_cnt_q == prescale_q);
   assign wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wmask};

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         pwm_led[i] = (pwm_cnt_q < duty_q[i]);
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         6'd0: rdata = {28'd0, ie_q, mode_q, en_q};
         6'd1: rdata[CNT_W-1:0] = prescale_q;
         6'd2: rdata[NUM_CH-1:0] = out_q;
         6'd3: begin
            rdata[NUM_CH-1:0]  = led_q;
            rdata[16 +: PWM_W] = pwm_cnt_q;
         end
         default: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (off == 6'(i + 4)) rdata[PWM_W-1:0] = duty_q[i];
            end
         end
      endcase
   end

   always_comb begin
      ack_d      = req;
      dat_d      = (req & ~wbs_we_i) ? rdata : '0;
      en_d       = en_q;
      mode_d     = mode_q;
      prescale_d = prescale_q;
      out_d      = out_q;
      for (int i = 0; i < NUM_CH; i++) duty_d[i] = duty_q[i];
      pre_cnt_d  = pre_cnt_q;
      pwm_cnt_d  = pwm_cnt_q;
      cnt_d      = cnt_q;

      if (cfg_wr) begin
         pre_cnt_d = '0;
         pwm_cnt_d = '0;
      end else if (en_q) begin
         pre_cnt_d = tick ? '0 : pre_cnt_q + CNT_W'(1);
      end
      if (tick && mode_q == 2'd0) cnt_d = cnt_q + NUM_CH'(1);
      if (tick && mode_q == 2'd1) pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

      if (wr) begin
         case (off)
            6'd0: begin
               if (wbs_sel_i[0]) begin
                  en_d   = wbs_dat_i[0];
                  mode_d = wbs_dat_i[2:1];
               end
            end
            6'd1: prescale_d = (prescale_q & ~wmask[CNT_W-1:0]) |
                               (wbs_dat_i[CNT_W-1:0] & wmask[CNT_W-1:0]);
            6'd2: out_d = (out_q & ~wmask[NUM_CH-1:0]) |
                          (wbs_dat_i[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (off == 6'(i + 4)) begin
                     duty_d[i] = (duty_q[i] & ~wmask[PWM_W-1:0]) |
                                 (wbs_dat_i[PWM_W-1:0] & wmask[PWM_W-1:0]);
                  end
               end
            end
         endcase
      end

      case (mode_q)
         2'd0:    led_d = cnt_q;
         2'd1:    led_d = pwm_led;
         default: led_d = out_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_q      <= 1'b0;
         dat_q      <= '0;
         en_q       <= 1'b1;
         mode_q     <= 2'd0;
         prescale_q <= '1;
         pre_cnt_q  <= '0;
         pwm_cnt_q  <= '0;
         out_q      <= '0;
         cnt_q      <= '0;
         led_q      <= '0;
         for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
      end else begin
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         en_q       <= en_d;
         mode_q     <= mode_d;
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         out_q      <= out_d;
         cnt_q      <= cnt_d;
         led_q      <= led_d;
         for (int i = 0; i < NUM_CH; i++) duty_q[i] <= duty_d[i];
      end
   end

`ifdef LED_IRQ_EN
   logic ie_d, wrap_q, wrap_d, irq_q, irq_d;

   // wrap_q delays the wrap event one cycle so irq lines up with led_o.
   always_comb begin
      ie_d = ie_q;
      if (wr && off == 6'd0 && wbs_sel_i[0]) ie_d = wbs_dat_i[3];
      wrap_d = tick & (((mode_q == 2'd0) & (cnt_q == '1)) |
                       ((mode_q == 2'd1) & (pwm_cnt_q == '1)));
      irq_d  = wrap_q & ie_q & en_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ie_q   <= 1'b0;
         wrap_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         ie_q   <= ie_d;
         wrap_q <= wrap_d;
         irq_q  <= irq_d;
      end
   end

   assign irq_o = irq_q;
`else
   assign ie_q  = 1'b0;
   assign irq_o = 1'b0;
`endif

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign led_o     = led_q;
   assign led_oeb_o = {NUM_CH{~en_q}};

endmodule

// File: tb/tb_wb_led_ctrl.sv
// Self-checking bench for wb_led_ctrl: directed scenarios plus random
// bus traffic compared every cycle against a behavioural model.
module tb_wb_led_ctrl;

   localparam int          NUM_CH = 7;
   localparam int          CNT_W  = 20;
   localparam int          PWM_W  = 8;
   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] CMAX   = (32'd1 << NUM_CH) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]        sel = 4'h0;
   logic [31:0]       dat_i = '0, adr = '0;
   logic              ack, irq;
   logic [31:0]       dat_o;
   logic [NUM_CH-1:0] led, oeb;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   wb_led_ctrl #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
      .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .led_o(led), .led_oeb_o(oeb), .irq_o(irq)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural model: integer counters and modular arithmetic.
   logic [31:0] m_presc, m_pre, m_out, m_cnt, m_pwm, m_led, m_rdat;
   logic [31:0] m_duty [NUM_CH];
   logic [1:0]  m_mode;
   bit          m_en, m_ie, m_ack, m_wrap, m_irq;

   function automatic logic [31:0] bmerge(input logic [31:0] old,
      input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] rd_model(input int o);
      if (o == 0) return {28'd0, m_ie, m_mode, m_en};
      if (o == 1) return m_presc;
      if (o == 2) return m_out;
      if (o == 3) return m_led | (m_pwm << 16);
      if (o >= 4 && o < 4 + NUM_CH) return m_duty[o-4];
      return 32'd0;
   endfunction

   always @(posedge clk) begin : model
      int          o;
      bit          acc, wr, cfg, tk, nwrap;
      logic [31:0] nled;
      if (!rst_n) begin
         m_en <= 1'b1; m_mode <= 2'd0; m_ie <= 1'b0;
         m_presc <= (32'd1 << CNT_W) - 1;
         m_pre <= 0; m_out <= 0; m_cnt <= 0; m_pwm <= 0; m_led <= 0;
         m_ack <= 0; m_rdat <= 0; m_wrap <= 0; m_irq <= 0;
         for (int i = 0; i < NUM_CH; i++) m_duty[i] <= 0;
      end else begin
         acc = stb && cyc && (adr[31:8] == BASE[31:8]) && !m_ack;
         wr  = acc && we;
         o   = int'(adr[7:2]);
         cfg = wr && (o < 2);
         nled = 0;
         if (m_mode == 0) nled = m_cnt;
         else if (m_mode == 1) begin
            for (int i = 0; i < NUM_CH; i++)
               if (m_pwm < m_duty[i]) nled[i] = 1'b1;
         end else nled = m_out;
`ifdef LED_IRQ_EN
         m_irq <= m_wrap && m_ie && m_en;
`else
         m_irq <= 1'b0;
`endif
         tk = m_en && !cfg && (m_pre == m_presc);
         nwrap = 0;
         if (cfg) begin
            m_pre <= 0;
            m_pwm <= 0;
         end else if (m_en) m_pre <= tk ? 0 : m_pre + 1;
         if (tk && m_mode == 0) begin
            nwrap = (m_cnt == CMAX);
            m_cnt <= (m_cnt + 1) % (32'd1 << NUM_CH);
         end
         if (tk && m_mode == 1) begin
            nwrap = (m_pwm == (32'd1 << PWM_W) - 1);
            m_pwm <= (m_pwm + 1) % (32'd1 << PWM_W);
         end
         m_wrap <= nwrap;
         if (wr) begin
            if (o == 0 && sel[0]) begin
               m_en <= dat_i[0];
               m_mode <= dat_i[2:1];
`ifdef LED_IRQ_EN
               m_ie <= dat_i[3];
`endif
            end
            if (o == 1)
               m_presc <= bmerge(m_presc, dat_i, sel) & ((32'd1 << CNT_W) - 1);
            if (o == 2) m_out <= bmerge(m_out, dat_i, sel) & CMAX;
            if (o >= 4 && o < 4 + NUM_CH)
               m_duty[o-4] <= bmerge(m_duty[o-4], dat_i, sel) & 32'hFF;
         end
         m_rdat <= (acc && !we) ? rd_model(o) : 0;
         m_ack  <= acc;
         m_led  <= nled;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ack", {31'd0, ack}, {31'd0, m_ack});
         chk("rdata", dat_o, m_rdat);
         chk("led", {25'd0, led}, m_led);
         chk("oeb", {25'd0, oeb}, m_en ? 32'd0 : CMAX);
         chk("irq", {31'd0, irq}, {31'd0, m_irq});
      end
   end

   task automatic cw(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] r,
                       output bit ok);
      stb = 1; cyc = 1; we = w; adr = a; sel = s; dat_i = d;
      ok = 0; r = 0;
      for (int k = 0; k < 4 && !ok; k++) begin
         cw(1);
         if (ack) begin ok = 1; r = dat_o; end
      end
      stb = 0; cyc = 0; we = 0;
   endtask

   task automatic wr(input logic [7:0] o, input logic [31:0] d);
      logic [31:0] r;
      bit ok;
      xfer(1, BASE | 32'(o), 4'hF, d, r, ok);
      chk("wr_ack", {31'd0, ok}, 32'd1);
   endtask

   task automatic rd(input logic [7:0] o, output logic [31:0] r);
      bit ok;
      xfer(0, BASE | 32'(o), 4'hF, 32'd0, r, ok);
      chk("rd_ack", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      logic [31:0] r, v;
      bit          ok;
      int          n0, n1, n2, np, last, gap;

      cw(2);
      chk_on = 1;
      rst_n = 1;
      chk("rst_led", {25'd0, led}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      rd(8'h00, r); chk("rst_ctrl", r, 32'd1);
      rd(8'h04, r); chk("rst_presc", r, 32'h000F_FFFF);
      rd(8'h10, r); chk("rst_duty0", r, 32'd0);

      // Count mode, tick every 4 cycles
      wr(8'h04, 32'd3);
      wr(8'h00, 32'd1);
      v = {25'd0, led};
      cw(5);
      chk("cnt_first", {25'd0, led}, (v + 1) & CMAX);
      for (int k = 2; k < 5; k++) begin
         cw(4);
         chk("cnt_step", {25'd0, led}, (v + k) & CMAX);
      end
      v = {25'd0, led};
      cw(256); chk("cnt_half", {25'd0, led}, (v + 64) & CMAX);
      cw(256); chk("cnt_wrap", {25'd0, led}, v);

      // Disable freezes the count and releases the pads
      wr(8'h00, 32'd0);
      chk("oeb_off", {25'd0, oeb}, CMAX);
      v = {25'd0, led};
      cw(20); chk("frozen", {25'd0, led}, v);
      wr(8'h00, 32'd1);
      chk("oeb_on", {25'd0, oeb}, 32'd0);
      cw(4); chk("resume_hold", {25'd0, led}, v);
      cw(1); chk("resume_step", {25'd0, led}, (v + 1) & CMAX);

      // PWM duty measurement
      wr(8'h10, 32'd64); wr(8'h14, 32'd0); wr(8'h18, 32'd255);
      wr(8'h04, 32'd0);
      wr(8'h00, 32'd3);
      cw(1);
      n0 = 0; n1 = 0; n2 = 0;
      for (int k = 0; k < 256; k++) begin
         n0 += int'(led[0]); n1 += int'(led[1]); n2 += int'(led[2]);
         cw(1);
      end
      chk("pwm_ch0", n0, 64);
      chk("pwm_ch1", n1, 0);
      chk("pwm_ch2", n2, 255);

      // Static mode
      wr(8'h08, 32'h55);
      wr(8'h00, 32'd5);
      cw(1); chk("static", {25'd0, led}, 32'h55);
      rd(8'h0C, r); chk("status_led", r & CMAX, 32'h55);
      wr(8'h08, 32'h2A);
      chk("static_lat", {25'd0, led}, 32'h55);
      cw(1); chk("static_new", {25'd0, led}, 32'h2A);

      // Unmapped, out-of-range DUTY, miss and byte select
      rd(8'h60, r); chk("unmapped", r, 32'd0);
      wr(8'h2C, 32'hFF);
      rd(8'h2C, r); chk("duty_oob", r, 32'd0);
      xfer(0, BASE + 32'h100, 4'hF, 32'd0, r, ok);
      chk("miss_noack", {31'd0, ok}, 32'd0);
      wr(8'h04, 32'h12345);
      xfer(1, BASE | 32'h4, 4'b0001, 32'hFFFF_FFAB, r, ok);
      rd(8'h04, r); chk("sel_byte0", r, 32'h123AB);

      // Wrap interrupt
      wr(8'h04, 32'd0);
      wr(8'h00, 32'd9);
      np = 0; last = -1; gap = 0;
      for (int k = 0; k < 384; k++) begin
         cw(1);
         if (irq) begin
            if (last >= 0) gap = k - last;
            last = k;
            np++;
         end
      end
      rd(8'h00, r);
`ifdef LED_IRQ_EN
      chk("irq_count", np, 3);
      chk("irq_gap", gap, 128);
      chk("ctrl_ie", r, 32'd9);
`else
      chk("irq_count", np, 0);
      chk("ctrl_ie", r, 32'd1);
`endif

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         logic [31:0] a, d;
         int          o;
         o = $urandom_range(0, NUM_CH + 5);
         a = BASE | 32'(o * 4);
         if ($urandom_range(0, 9) == 0) a = a + 32'h100;
         d = $urandom;
         if (o == 1) d = d & 32'h3;
         xfer($urandom_range(0, 1) == 1, a, 4'($urandom_range(0, 15)),
              d, r, ok);
         cw($urandom_range(0, 3));
      end

      // Reset during a transaction
      stb = 1; cyc = 1; we = 0; adr = BASE;
      cw(1);
      rst_n = 0;
      cw(1);
      stb = 0; cyc = 0;
      rst_n = 1;
      chk("rst2_ack", {31'd0, ack}, 32'd0);
      chk("rst2_led", {25'd0, led}, 32'd0);
      rd(8'h00, r); chk("rst2_ctrl", r, 32'd1);

      cw(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
